// File: rtl/lia_regs_pkg.sv
// Lock-in amplifier register map shared by the Avalon-MM register block and its users.
// Holds word addresses of each register or register window and the CTRL/STATUS bit indices.
package lia_regs_pkg;

  // Word addresses on the 5-bit Avalon-MM address bus.
  localparam logic [4:0] ADDR_INCR_BASE = 5'h00;  // 0x00-0x07 per-channel phase increment
  localparam logic [4:0] ADDR_OFFS_BASE = 5'h08;  // 0x08-0x0F per-channel phase offset
  localparam logic [4:0] ADDR_GAIN_CTRL = 5'h10;
  localparam logic [4:0] ADDR_DAC_GAIN  = 5'h11;
  localparam logic [4:0] ADDR_CTRL      = 5'h12;  // write-only strobes
  localparam logic [4:0] ADDR_STATUS    = 5'h13;  // read-only
  localparam logic [4:0] ADDR_SNAP_BASE = 5'h14;  // 0x14-0x1B per-channel {Y, X} snapshot

  // CTRL bits.
  localparam int unsigned CTRL_COMMIT_BIT = 0;
  localparam int unsigned CTRL_SNAP_BIT   = 1;

  // STATUS bits.
  localparam int unsigned STATUS_COMMIT_PEND_BIT = 0;
  localparam int unsigned STATUS_SNAP_PEND_BIT   = 1;
  localparam int unsigned STATUS_SNAP_VALID_BIT  = 2;

endpackage

// File: rtl/lia_avalon_regs.sv
// Avalon-MM control/status registers for a multi-channel lock-in amplifier.
// Phase increments/offsets are written into shadow registers and copied to the active outputs
// atomically on an NCO frame tick after a COMMIT request. X/Y results are captured into
// snapshot registers on a lock-in sample strobe after a SNAP request.
// Ports:
//   clk_clk, reset_reset_n           clock, asynchronous active-low reset
//   avs_*                            Avalon-MM slave, zero-wait writes, read latency 1
//   sync_tick                        NCO frame strobe (commit point)
//   sample_valid                     lock-in output strobe (snapshot point)
//   lia_x_in / lia_y_in              flattened per-channel X/Y results
//   phase_incr_out / phase_offs_out  flattened active per-channel phase settings
//   gain_ctrl_out / dac_gain_out     active gain settings
module lia_avalon_regs
  import lia_regs_pkg::*;
#(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned PHASE_W = 20,
  parameter int unsigned DATA_W  = 16
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic [4:0]                avs_address,
  input  logic                      avs_write,
  input  logic                      avs_read,
  input  logic [31:0]               avs_writedata,
  output logic [31:0]               avs_readdata,
  output logic                      avs_readdatavalid,
  input  logic                      sync_tick,
  input  logic                      sample_valid,
  input  logic [N_CH*DATA_W-1:0]    lia_x_in,
  input  logic [N_CH*DATA_W-1:0]    lia_y_in,
  output logic [N_CH*PHASE_W-1:0]   phase_incr_out,
  output logic [N_CH*PHASE_W-1:0]   phase_offs_out,
  output logic [5:0]                gain_ctrl_out,
  output logic [7:0]                dac_gain_out
);

  logic        ctrl_wr, commit_fire, snap_fire;
  logic        commit_pending_d, commit_pending_q;
  logic        snap_pending_d, snap_pending_q;
  logic        snap_valid_d, snap_valid_q;
  logic [5:0]  gain_ctrl_d, gain_ctrl_q;
  logic [7:0]  dac_gain_d, dac_gain_q;
  logic [31:0] rd_mux, status_word;
  logic [31:0] readdata_d, readdata_q;
  logic        readdatavalid_d, readdatavalid_q;

  logic [N_CH*PHASE_W-1:0] incr_shadow_flat, offs_shadow_flat;
  logic [N_CH*32-1:0]      snap_flat;

  // Upper write-data bits beyond the widest field are intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  always_comb begin
    ctrl_wr     = avs_write && (avs_address == ADDR_CTRL);
    // Transfers key off the registered pending flags, so a request written in the same
    // cycle as a strobe waits for the following strobe.
    commit_fire = sync_tick && commit_pending_q;
    snap_fire   = sample_valid && snap_pending_q;

    commit_pending_d = commit_pending_q;
    if (commit_fire) commit_pending_d = 1'b0;
    if (ctrl_wr && avs_writedata[CTRL_COMMIT_BIT]) commit_pending_d = 1'b1;

    snap_pending_d = snap_pending_q;
    snap_valid_d   = snap_valid_q;
    if (snap_fire) begin
      snap_pending_d = 1'b0;
      snap_valid_d   = 1'b1;
    end
    if (ctrl_wr && avs_writedata[CTRL_SNAP_BIT]) begin
      snap_pending_d = 1'b1;
      snap_valid_d   = 1'b0;
    end

    gain_ctrl_d = (avs_write && (avs_address == ADDR_GAIN_CTRL)) ? avs_writedata[5:0]
                                                                 : gain_ctrl_q;
    dac_gain_d  = (avs_write && (avs_address == ADDR_DAC_GAIN)) ? avs_writedata[7:0]
                                                                : dac_gain_q;
  end

  // Per-channel shadow/active phase registers and snapshot registers.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam logic [4:0] IncrAddr = ADDR_INCR_BASE + 5'(k);
    localparam logic [4:0] OffsAddr = ADDR_OFFS_BASE + 5'(k);

    logic [PHASE_W-1:0] incr_shadow_d, incr_shadow_q, offs_shadow_d, offs_shadow_q;
    logic [PHASE_W-1:0] incr_active_d, incr_active_q, offs_active_d, offs_active_q;
    logic [DATA_W-1:0]  snap_x_d, snap_x_q, snap_y_d, snap_y_q;

    always_comb begin
      incr_shadow_d = (avs_write && (avs_address == IncrAddr)) ? avs_writedata[PHASE_W-1:0]
                                                               : incr_shadow_q;
      offs_shadow_d = (avs_write && (avs_address == OffsAddr)) ? avs_writedata[PHASE_W-1:0]
                                                               : offs_shadow_q;
      // Active copy takes the pre-write shadow, so a coincident shadow write waits.
      incr_active_d = commit_fire ? incr_shadow_q : incr_active_q;
      offs_active_d = commit_fire ? offs_shadow_q : offs_active_q;
      snap_x_d      = snap_fire ? lia_x_in[k*DATA_W +: DATA_W] : snap_x_q;
      snap_y_d      = snap_fire ? lia_y_in[k*DATA_W +: DATA_W] : snap_y_q;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        incr_shadow_q <= '0;
        offs_shadow_q <= '0;
        incr_active_q <= '0;
        offs_active_q <= '0;
        snap_x_q      <= '0;
        snap_y_q      <= '0;
      end else begin
        incr_shadow_q <= incr_shadow_d;
        offs_shadow_q <= offs_shadow_d;
        incr_active_q <= incr_active_d;
        offs_active_q <= offs_active_d;
        snap_x_q      <= snap_x_d;
        snap_y_q      <= snap_y_d;
      end
    end

    assign phase_incr_out[k*PHASE_W +: PHASE_W]   = incr_active_q;
    assign phase_offs_out[k*PHASE_W +: PHASE_W]   = offs_active_q;
    assign incr_shadow_flat[k*PHASE_W +: PHASE_W] = incr_shadow_q;
    assign offs_shadow_flat[k*PHASE_W +: PHASE_W] = offs_shadow_q;
    assign snap_flat[k*32 +: 32]                  = {16'(snap_y_q), 16'(snap_x_q)};
  end

  // Read mux; CTRL and unmapped addresses fall through to zero.
  always_comb begin
    status_word                         = '0;
    status_word[STATUS_COMMIT_PEND_BIT] = commit_pending_q;
    status_word[STATUS_SNAP_PEND_BIT]   = snap_pending_q;
    status_word[STATUS_SNAP_VALID_BIT]  = snap_valid_q;

    rd_mux = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (avs_address == ADDR_INCR_BASE + 5'(k)) rd_mux = 32'(incr_shadow_flat[k*PHASE_W +: PHASE_W]);
      if (avs_address == ADDR_OFFS_BASE + 5'(k)) rd_mux = 32'(offs_shadow_flat[k*PHASE_W +: PHASE_W]);
      if (avs_address == ADDR_SNAP_BASE + 5'(k)) rd_mux = snap_flat[k*32 +: 32];
    end
    if (avs_address == ADDR_GAIN_CTRL) rd_mux = {26'd0, gain_ctrl_q};
    if (avs_address == ADDR_DAC_GAIN)  rd_mux = {24'd0, dac_gain_q};
    if (avs_address == ADDR_STATUS)    rd_mux = status_word;

    readdata_d      = avs_read ? rd_mux : readdata_q;
    readdatavalid_d = avs_read;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      commit_pending_q <= 1'b0;
      snap_pending_q   <= 1'b0;
      snap_valid_q     <= 1'b0;
      gain_ctrl_q      <= '0;
      dac_gain_q       <= '0;
      readdata_q       <= '0;
      readdatavalid_q  <= 1'b0;
    end else begin
      commit_pending_q <= commit_pending_d;
      snap_pending_q   <= snap_pending_d;
      snap_valid_q     <= snap_valid_d;
      gain_ctrl_q      <= gain_ctrl_d;
      dac_gain_q       <= dac_gain_d;
      readdata_q       <= readdata_d;
      readdatavalid_q  <= readdatavalid_d;
    end
  end

  assign gain_ctrl_out     = gain_ctrl_q;
  assign dac_gain_out      = dac_gain_q;
  assign avs_readdata      = readdata_q;
  assign avs_readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_lia_avalon_regs.sv
// Self-checking bench for lia_avalon_regs with a register-map level reference model.
module tb_lia_avalon_regs;
  localparam int NCH = 8;
  localparam int PW  = 20;
  localparam int DW  = 16;

  logic                clk;
  logic                rst_n;
  logic [4:0]          avs_address;
  logic                avs_write, avs_read;
  logic [31:0]         avs_writedata;
  logic [31:0]         avs_readdata;
  logic                avs_readdatavalid;
  logic                sync_tick, sample_valid;
  logic [NCH*DW-1:0]   lia_x, lia_y;
  logic [NCH*PW-1:0]   phase_incr_out, phase_offs_out;
  logic [5:0]          gain_ctrl_out;
  logic [7:0]          dac_gain_out;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [PW-1:0] m_incr_sh [NCH];
  logic [PW-1:0] m_offs_sh [NCH];
  logic [PW-1:0] m_incr_act[NCH];
  logic [PW-1:0] m_offs_act[NCH];
  logic [15:0]   m_sx[NCH];
  logic [15:0]   m_sy[NCH];
  bit            m_cp, m_sp, m_sv;
  logic [5:0]    m_gain;
  logic [7:0]    m_dac;
  logic [31:0]   m_rdata;
  bit            m_rvalid;

  lia_avalon_regs #(.N_CH(NCH), .PHASE_W(PW), .DATA_W(DW)) dut (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .avs_address      (avs_address),
    .avs_write        (avs_write),
    .avs_read         (avs_read),
    .avs_writedata    (avs_writedata),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .sync_tick        (sync_tick),
    .sample_valid     (sample_valid),
    .lia_x_in         (lia_x),
    .lia_y_in         (lia_y),
    .phase_incr_out   (phase_incr_out),
    .phase_offs_out   (phase_offs_out),
    .gain_ctrl_out    (gain_ctrl_out),
    .dac_gain_out     (dac_gain_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_incr_sh[i] = '0; m_offs_sh[i] = '0; m_incr_act[i] = '0; m_offs_act[i] = '0;
      m_sx[i] = '0; m_sy[i] = '0;
    end
    m_cp = 0; m_sp = 0; m_sv = 0; m_gain = '0; m_dac = '0; m_rdata = '0; m_rvalid = 0;
  endtask

  function automatic logic [31:0] model_read(input int a);
    if (a < 8)              return 32'(m_incr_sh[a]);
    if (a < 16)             return 32'(m_offs_sh[a-8]);
    if (a == 16)            return {26'd0, m_gain};
    if (a == 17)            return {24'd0, m_dac};
    if (a == 19)            return {29'd0, m_sv, m_sp, m_cp};
    if (a >= 20 && a < 28)  return {m_sy[a-20], m_sx[a-20]};
    return 32'd0;
  endfunction

  function automatic logic [NCH*PW-1:0] exp_incr();
    logic [NCH*PW-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*PW +: PW] = m_incr_act[i];
    return v;
  endfunction

  function automatic logic [NCH*PW-1:0] exp_offs();
    logic [NCH*PW-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*PW +: PW] = m_offs_act[i];
    return v;
  endfunction

  // Advance one clock: update the model from the inputs presented before the edge, then
  // land 1 time unit after the edge and drop single-cycle strobes.
  task automatic cycle();
    logic [31:0] rd_n;
    bit          rv_n;
    int          a;
    a    = int'(avs_address);
    rv_n = avs_read;
    rd_n = avs_read ? model_read(a) : m_rdata;
    if (sync_tick && m_cp) begin
      for (int i = 0; i < NCH; i++) begin
        m_incr_act[i] = m_incr_sh[i];
        m_offs_act[i] = m_offs_sh[i];
      end
      m_cp = 0;
    end
    if (sample_valid && m_sp) begin
      for (int i = 0; i < NCH; i++) begin
        m_sx[i] = lia_x[i*DW +: DW];
        m_sy[i] = lia_y[i*DW +: DW];
      end
      m_sp = 0;
      m_sv = 1;
    end
    if (avs_write) begin
      if (a < 8)        m_incr_sh[a]   = avs_writedata[PW-1:0];
      else if (a < 16)  m_offs_sh[a-8] = avs_writedata[PW-1:0];
      else if (a == 16) m_gain         = avs_writedata[5:0];
      else if (a == 17) m_dac          = avs_writedata[7:0];
      else if (a == 18) begin
        if (avs_writedata[0]) m_cp = 1;
        if (avs_writedata[1]) begin m_sp = 1; m_sv = 0; end
      end
    end
    @(posedge clk);
    #1;
    m_rdata  = rd_n;
    m_rvalid = rv_n;
    avs_write = 0; avs_read = 0; sync_tick = 0; sample_valid = 0;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    avs_write = 1; avs_address = a; avs_writedata = d;
    cycle();
  endtask

  task automatic bus_read(input logic [4:0] a);
    avs_read = 1; avs_address = a;
    cycle();
  endtask

  task automatic randomize_lia();
    for (int i = 0; i < NCH; i++) begin
      lia_x[i*DW +: DW] = 16'($urandom);
      lia_y[i*DW +: DW] = 16'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    checks++; if (phase_incr_out !== '0) begin errors++; $display("FAIL rst_incr got %h exp 0", phase_incr_out); end
    checks++; if (phase_offs_out !== '0) begin errors++; $display("FAIL rst_offs got %h exp 0", phase_offs_out); end
    checks++; if ({gain_ctrl_out, dac_gain_out} !== 14'd0) begin errors++; $display("FAIL rst_gain got %h/%h exp 0", gain_ctrl_out, dac_gain_out); end
    checks++; if ({avs_readdatavalid, avs_readdata} !== 33'd0) begin errors++; $display("FAIL rst_rd got %b/%h exp 0", avs_readdatavalid, avs_readdata); end
    rst_n = 1;
    cycle();
    bus_read(5'h13);
    checks++; if (!avs_readdatavalid || avs_readdata !== 32'h0) begin errors++; $display("FAIL rst_status got %b/%h exp 1/0", avs_readdatavalid, avs_readdata); end
    bus_read(5'h1B);
    checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL rst_snap7 got %h exp 0", avs_readdata); end
  endtask

  task automatic test_commit_hold();
    bus_write(5'h03, 32'hFFF1_2345);
    bus_write(5'h12, 32'h1);
    for (int i = 0; i < 50; i++) begin
      cycle();
      checks++; if (phase_incr_out[3*PW +: PW] !== 20'h0) begin errors++; $display("FAIL hold_ch3 cyc %0d got %h exp 0", i, phase_incr_out[3*PW +: PW]); end
    end
    bus_read(5'h13);
    checks++; if (avs_readdata !== 32'h1) begin errors++; $display("FAIL hold_status got %h exp 1", avs_readdata); end
    sync_tick = 1;
    cycle();
    checks++; if (phase_incr_out[3*PW +: PW] !== 20'h12345) begin errors++; $display("FAIL tick_ch3 got %h exp 12345", phase_incr_out[3*PW +: PW]); end
    checks++; if (phase_incr_out !== exp_incr()) begin errors++; $display("FAIL tick_all got %h exp %h", phase_incr_out, exp_incr()); end
    bus_read(5'h13);
    checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL tick_status got %h exp 0", avs_readdata); end
  endtask

  task automatic test_commit_coincident();
    logic [PW-1:0] v, a, b;
    v = PW'($urandom) | 20'h1;
    bus_write(5'h00, 32'(v));
    avs_write = 1; avs_address = 5'h12; avs_writedata = 32'h1; sync_tick = 1;
    cycle();
    checks++; if (phase_incr_out[0 +: PW] !== 20'h0) begin errors++; $display("FAIL coinc_noupd got %h exp 0", phase_incr_out[0 +: PW]); end
    sync_tick = 1;
    cycle();
    checks++; if (phase_incr_out[0 +: PW] !== v) begin errors++; $display("FAIL coinc_next got %h exp %h", phase_incr_out[0 +: PW], v); end
    // Shadow write on the transfer edge: active gets the old shadow.
    a = PW'($urandom); b = ~a;
    bus_write(5'h09, 32'(a));
    bus_write(5'h12, 32'h1);
    avs_write = 1; avs_address = 5'h09; avs_writedata = 32'(b); sync_tick = 1;
    cycle();
    checks++; if (phase_offs_out[PW +: PW] !== a) begin errors++; $display("FAIL prewrite_act got %h exp %h", phase_offs_out[PW +: PW], a); end
    bus_read(5'h09);
    checks++; if (avs_readdata !== 32'(b)) begin errors++; $display("FAIL prewrite_sh got %h exp %h", avs_readdata, 32'(b)); end
  endtask

  task automatic test_snapshot();
    randomize_lia();
    lia_x[0 +: DW] = 16'h7FFF; lia_y[0 +: DW] = 16'h8000;
    lia_x[7*DW +: DW] = 16'h0001; lia_y[7*DW +: DW] = 16'hFFFF;
    bus_write(5'h12, 32'h2);
    bus_read(5'h13);
    checks++; if (avs_readdata !== 32'h2) begin errors++; $display("FAIL snap_pend got %h exp 2", avs_readdata); end
    sample_valid = 1;
    cycle();
    randomize_lia();
    sample_valid = 1;
    cycle();
    bus_read(5'h14);
    checks++; if (avs_readdata !== 32'h8000_7FFF) begin errors++; $display("FAIL snap0 got %h exp 80007fff", avs_readdata); end
    bus_read(5'h1B);
    checks++; if (avs_readdata !== 32'hFFFF_0001) begin errors++; $display("FAIL snap7 got %h exp ffff0001", avs_readdata); end
    bus_read(5'h13);
    checks++; if (avs_readdata !== 32'h4) begin errors++; $display("FAIL snap_status got %h exp 4", avs_readdata); end
    for (int k = 1; k < 7; k++) begin
      bus_read(5'(20 + k));
      checks++; if (avs_readdata !== m_rdata) begin errors++; $display("FAIL snap_ch%0d got %h exp %h", k, avs_readdata, m_rdata); end
    end
    // SNAP write coincident with a strobe captures at the next strobe.
    randomize_lia();
    avs_write = 1; avs_address = 5'h12; avs_writedata = 32'h2; sample_valid = 1;
    cycle();
    bus_read(5'h13);
    checks++; if (avs_readdata !== 32'h2) begin errors++; $display("FAIL snap_coinc got %h exp 2", avs_readdata); end
    sample_valid = 1;
    cycle();
    bus_read(5'h14);
    checks++; if (avs_readdata !== m_rdata) begin errors++; $display("FAIL snap_recap got %h exp %h", avs_readdata, m_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] g;
    g = 6'($urandom_range(1, 63));
    bus_write(5'h10, {$urandom, 6'h0} | 32'(g));
    avs_read = 1; avs_address = 5'h10;
    cycle();
    checks++; if (avs_readdatavalid !== 1'b1 || avs_readdata !== {26'd0, g}) begin errors++; $display("FAIL b2b_gain got %b/%h exp 1/%h", avs_readdatavalid, avs_readdata, g); end
    avs_read = 1; avs_address = 5'h1F;
    cycle();
    checks++; if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'h0) begin errors++; $display("FAIL b2b_unmapped got %b/%h exp 1/0", avs_readdatavalid, avs_readdata); end
    avs_read = 1; avs_address = 5'h12;
    cycle();
    checks++; if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'h0) begin errors++; $display("FAIL b2b_ctrl got %b/%h exp 1/0", avs_readdatavalid, avs_readdata); end
    cycle();
    checks++; if (avs_readdatavalid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", avs_readdatavalid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int r;
      randomize_lia();
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        avs_write = 1; avs_address = 5'($urandom); avs_writedata = $urandom;
      end else if (r < 80) begin
        avs_read = 1; avs_address = 5'($urandom);
      end
      sync_tick    = ($urandom_range(0, 7) == 0);
      sample_valid = ($urandom_range(0, 7) == 0);
      cycle();
      checks++; if ({phase_incr_out, phase_offs_out} !== {exp_incr(), exp_offs()}) begin errors++; $display("FAIL rand_phase n=%0d got %h/%h exp %h/%h", n, phase_incr_out, phase_offs_out, exp_incr(), exp_offs()); end
      checks++; if ({gain_ctrl_out, dac_gain_out, avs_readdatavalid, avs_readdata} !== {m_gain, m_dac, m_rvalid, m_rdata}) begin errors++; $display("FAIL rand_misc n=%0d got %h/%h/%b/%h exp %h/%h/%b/%h", n, gain_ctrl_out, dac_gain_out, avs_readdatavalid, avs_readdata, m_gain, m_dac, m_rvalid, m_rdata); end
    end
  endtask

  task automatic test_reset_midop();
    bus_write(5'h05, 32'($urandom) | 32'h1);
    bus_write(5'h0D, 32'($urandom) | 32'h1);
    bus_write(5'h11, 32'hA5);
    bus_write(5'h12, 32'h1);
    sync_tick = 1;
    cycle();
    bus_write(5'h05, 32'h3);
    bus_write(5'h12, 32'h3);
    #3;
    rst_n = 0;
    #1;
    model_clear();
    checks++; if (phase_incr_out !== '0 || phase_offs_out !== '0) begin errors++; $display("FAIL midrst_phase got %h/%h exp 0", phase_incr_out, phase_offs_out); end
    checks++; if ({gain_ctrl_out, dac_gain_out, avs_readdatavalid, avs_readdata} !== 47'd0) begin errors++; $display("FAIL midrst_misc got %h/%h/%b/%h exp 0", gain_ctrl_out, dac_gain_out, avs_readdatavalid, avs_readdata); end
    #2;
    rst_n = 1;
    sync_tick = 1; sample_valid = 1;
    cycle();
    checks++; if (phase_incr_out !== '0 || phase_offs_out !== '0) begin errors++; $display("FAIL midrst_tick got %h/%h exp 0", phase_incr_out, phase_offs_out); end
    bus_read(5'h13);
    checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL midrst_status got %h exp 0", avs_readdata); end
  endtask

  initial begin
    avs_address = '0; avs_write = 0; avs_read = 0; avs_writedata = '0;
    sync_tick = 0; sample_valid = 0; lia_x = '0; lia_y = '0;
    model_clear();
    test_reset();
    test_commit_hold();
    test_commit_coincident();
    test_snapshot();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
